// File: rtl/cmu_if.sv
// Memory-side word transfer bus between the cache management unit and the next memory level.
interface cmu_if #(
    parameter int unsigned ADDR_BITS = 32
) ();
    logic                 mem_cs_o;
    logic                 mem_we_o;
    logic [ADDR_BITS-1:0] mem_addr_o;
    logic [31:0]          mem_data_o;
    logic [31:0]          mem_data_i;
    logic                 mem_ack_i;

    modport master (
        output mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport slave (
        input  mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/cmu.sv
// Cache management unit: serves CPU hits from the cache array and, on a miss,
// writes back a dirty victim line and refills the requested line word by word.
module cmu #(
    parameter int unsigned ADDR_BITS  = 32,
    parameter int unsigned TAG_BITS   = 23,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr_rw,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [2:0]           u_b_h_w,
    input  logic [31:0]          data_w,
    output logic [31:0]          data_r,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_store,
    output logic                 cache_replace,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic [31:0]          cache_dout,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    cmu_if.master                mem
);
    localparam int unsigned WORD_BITS = $clog2(LINE_WORDS);
    localparam int unsigned OFF_BITS  = WORD_BITS + 2;
    localparam int unsigned IDX_BITS  = ADDR_BITS - TAG_BITS - OFF_BITS;
    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);
    localparam logic [2:0]           FMT_WORD  = 3'b010;

    typedef enum logic [1:0] {IDLE, BACK, FILL, WAIT} state_t;

    state_t                 state, state_nx;
    logic [WORD_BITS-1:0]   word_cnt, word_cnt_nx;
    logic                   req;
    logic [ADDR_BITS-1:0]   line_addr;
    logic [ADDR_BITS-1:0]   victim_addr;

    assign req         = en_r | en_w;
    assign line_addr   = {addr_rw[ADDR_BITS-1:OFF_BITS], word_cnt, 2'b00};
    assign victim_addr = {cache_tag, addr_rw[OFF_BITS+IDX_BITS-1:OFF_BITS], word_cnt, 2'b00};

    // State and word counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            word_cnt <= '0;
        end else begin
            state    <= state_nx;
            word_cnt <= word_cnt_nx;
        end
    end

    // Next-state: each memory ack retires one word; the last word advances the phase
    always_comb begin
        state_nx    = state;
        word_cnt_nx = word_cnt;
        case (state)
            IDLE: begin
                if (req && !cache_hit) begin
                    word_cnt_nx = '0;
                    state_nx    = (cache_valid && cache_dirty) ? BACK : FILL;
                end
            end
            BACK: begin
                if (mem.mem_ack_i) begin
                    word_cnt_nx = word_cnt + WORD_BITS'(1);
                    if (word_cnt == LAST_WORD) state_nx = FILL;
                end
            end
            FILL: begin
                if (mem.mem_ack_i) begin
                    word_cnt_nx = word_cnt + WORD_BITS'(1);
                    if (word_cnt == LAST_WORD) state_nx = WAIT;
                end
            end
            WAIT: state_nx = IDLE;
        endcase
    end

    // Outputs follow the current state and CPU/cache inputs; reset forces them all low at once
    always_comb begin
        data_r         = '0;
        stall          = 1'b0;
        cache_addr     = '0;
        cache_load     = 1'b0;
        cache_store    = 1'b0;
        cache_replace  = 1'b0;
        cache_u_b_h_w  = '0;
        cache_din      = '0;
        mem.mem_cs_o   = 1'b0;
        mem.mem_we_o   = 1'b0;
        mem.mem_addr_o = '0;
        mem.mem_data_o = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cache_addr    = addr_rw;
                        cache_u_b_h_w = u_b_h_w;
                        if (cache_hit) begin
                            cache_load  = en_r & ~en_w;
                            cache_store = en_w;
                            cache_din   = data_w;
                            data_r      = cache_dout;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                BACK: begin
                    stall          = 1'b1;
                    cache_addr     = line_addr;
                    cache_u_b_h_w  = FMT_WORD;
                    mem.mem_cs_o   = 1'b1;
                    mem.mem_we_o   = 1'b1;
                    mem.mem_addr_o = victim_addr;
                    mem.mem_data_o = cache_dout;
                end
                FILL: begin
                    stall          = 1'b1;
                    cache_addr     = line_addr;
                    mem.mem_cs_o   = 1'b1;
                    mem.mem_addr_o = line_addr;
                    if (mem.mem_ack_i) begin
                        cache_replace = 1'b1;
                        cache_din     = mem.mem_data_i;
                        cache_u_b_h_w = FMT_WORD;
                    end
                end
                WAIT: stall = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_cmu.sv
// Bench for cmu: a behavioural cache array and memory surround the DUT; a flat golden
// memory plus a line-residency model predict load data and stall latency.
module tb_cmu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_rw = '0;
    logic        en_r = 1'b0;
    logic        en_w = 1'b0;
    logic [2:0]  u_b_h_w = '0;
    logic [31:0] data_w = '0;
    logic [31:0] data_r;
    logic        stall;
    logic [31:0] cache_addr;
    logic        cache_load, cache_store, cache_replace;
    logic [2:0]  cache_u_b_h_w;
    logic [31:0] cache_din;
    logic [31:0] cache_dout;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [22:0] cache_tag;

    cmu_if #(.ADDR_BITS(32)) mem_bus ();

    cmu dut (
        .clk(clk), .rst(rst), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
        .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
        .cache_addr(cache_addr), .cache_load(cache_load), .cache_store(cache_store),
        .cache_replace(cache_replace), .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din),
        .cache_dout(cache_dout), .cache_hit(cache_hit), .cache_valid(cache_valid),
        .cache_dirty(cache_dirty), .cache_tag(cache_tag), .mem(mem_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared data helpers ----------------
    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (f)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f, input logic [31:0] d);
        logic [31:0] m;
        logic [4:0]  sh;
        sh = {off, 3'b000};
        case (f[1:0])
            2'b00:   m = 32'h0000_00FF << sh;
            2'b01:   m = 32'h0000_FFFF << sh;
            default: m = 32'hFFFF_FFFF;
        endcase
        return (w & ~m) | ((d << sh) & m);
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_A5A5;
    endfunction

    // ---------------- behavioural cache array (environment) ----------------
    logic [31:0] c_data [32][4];
    logic [22:0] c_tag [32];
    logic        c_valid [32];
    logic        c_dirty [32];
    logic        cache_clr = 1'b1;
    logic [4:0]  c_idx;
    logic [1:0]  c_w;
    logic [31:0] rep_log [$];

    always_comb begin
        c_idx       = cache_addr[8:4];
        c_w         = cache_addr[3:2];
        cache_tag   = c_tag[c_idx];
        cache_valid = c_valid[c_idx];
        cache_dirty = c_dirty[c_idx];
        cache_hit   = c_valid[c_idx] && (c_tag[c_idx] == cache_addr[31:9]);
        cache_dout  = ld_ext(c_data[c_idx][c_w], cache_addr[1:0], cache_u_b_h_w);
    end

    always @(posedge clk) begin
        if (cache_clr) begin
            for (int i = 0; i < 32; i++) begin
                c_valid[i] <= 1'b0;
                c_dirty[i] <= 1'b0;
            end
        end else begin
            if (cache_replace) begin
                c_data[c_idx][c_w] <= cache_din;
                rep_log.push_back(cache_addr);
                if (c_w == 2'd3) begin
                    c_valid[c_idx] <= 1'b1;
                    c_tag[c_idx]   <= cache_addr[31:9];
                    c_dirty[c_idx] <= 1'b0;
                end
            end
            if (cache_store) begin
                c_data[c_idx][c_w] <= st_merge(c_data[c_idx][c_w], cache_addr[1:0], cache_u_b_h_w, cache_din);
                c_dirty[c_idx]     <= 1'b1;
            end
        end
    end

    // ---------------- behavioural memory: ack every k_lat cycles per word ----------------
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] mlog_addr [$];
    logic        mlog_we [$];
    logic [31:0] mlog_data [$];
    int          k_lat = 1;
    int          m_cnt = 0;
    logic [31:0] block_addr = '0;
    int          block_until = 0;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;

    assign mem_bus.mem_ack_i  = m_ack;
    assign mem_bus.mem_data_i = m_rdata;

    always begin
        @(posedge clk);
        #2;
        if (!rst || mem_bus.mem_cs_o !== 1'b1) begin
            m_ack = 1'b0;
            m_cnt = 0;
        end else if (mem_bus.mem_addr_o == block_addr && cyc < block_until) begin
            m_ack = 1'b0;
        end else begin
            m_cnt++;
            if (m_cnt >= k_lat) begin
                m_ack = 1'b1;
                m_cnt = 0;
                mlog_addr.push_back(mem_bus.mem_addr_o);
                mlog_we.push_back(mem_bus.mem_we_o);
                mlog_data.push_back(mem_bus.mem_data_o);
                if (mem_bus.mem_we_o) bmem[mem_bus.mem_addr_o] = mem_bus.mem_data_o;
                else m_rdata = bmem.exists(mem_bus.mem_addr_o) ? bmem[mem_bus.mem_addr_o]
                                                                : init_word(mem_bus.mem_addr_o);
            end else begin
                m_ack = 1'b0;
            end
        end
    end

    // ---------------- reference model: golden memory + line residency ----------------
    logic [31:0] gold [logic [31:0]];
    logic        r_valid [32];
    logic        r_dirty [32];
    logic [22:0] r_tag [32];

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return gold.exists(wa) ? gold[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f);
        return ld_ext(gold_rd(a), a[1:0], f);
    endfunction

    function automatic int exp_stall(input logic [31:0] a, input int k);
        logic [4:0] idx;
        idx = a[8:4];
        if (r_valid[idx] && r_tag[idx] == a[31:9]) return 0;
        return (r_valid[idx] && r_dirty[idx]) ? 8 * k + 2 : 4 * k + 2;
    endfunction

    task automatic model_commit(input logic wr, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        logic [4:0] idx;
        idx = a[8:4];
        if (!(r_valid[idx] && r_tag[idx] == a[31:9])) begin
            r_valid[idx] = 1'b1;
            r_tag[idx]   = a[31:9];
            r_dirty[idx] = 1'b0;
        end
        if (wr) begin
            r_dirty[idx] = 1'b1;
            gold[{a[31:2], 2'b00}] = st_merge(gold_rd(a), a[1:0], f, d);
        end
    endtask

    // One CPU request held until stall drops; returns stall cycles (-1 on timeout) and load data
    task automatic do_req(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input int k, output int cyc_st, output logic [31:0] rd);
        k_lat = k;
        @(posedge clk);
        #1;
        addr_rw = a; en_r = r; en_w = w; u_b_h_w = f; data_w = d;
        cyc_st = 0;
        @(negedge clk);
        while (stall === 1'b1 && cyc_st < 1000) begin
            cyc_st++;
            @(negedge clk);
        end
        if (stall !== 1'b0) cyc_st = -1;
        rd = data_r;
        @(posedge clk);
        #1;
        en_r = 1'b0; en_w = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            r_valid[i] = 1'b0; r_dirty[i] = 1'b0; r_tag[i] = '0;
        end
        rst = 1'b0; cache_clr = 1'b1;
        addr_rw = 32'h0000_0040; en_r = 1'b1; en_w = 1'b1; u_b_h_w = 3'b010; data_w = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (mem_bus.mem_cs_o !== 1'b0 || mem_bus.mem_we_o !== 1'b0) begin failures++;
            $display("FAIL reset_mem_cs: got cs=%b we=%b want 0", mem_bus.mem_cs_o, mem_bus.mem_we_o); end
        checks++; if ({cache_load, cache_store, cache_replace} !== 3'b000) begin failures++;
            $display("FAIL reset_strobes: got %b want 000", {cache_load, cache_store, cache_replace}); end
        checks++; if (cache_addr !== 32'h0 || data_r !== 32'h0) begin failures++;
            $display("FAIL reset_outputs: got cache_addr=%h data_r=%h want 0", cache_addr, data_r); end
        en_r = 1'b0; en_w = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cache_clr = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || mem_bus.mem_cs_o !== 1'b0) begin failures++;
            $display("FAIL idle_after_reset: got stall=%b cs=%b want 0 0", stall, mem_bus.mem_cs_o); end
    endtask

    task automatic test_read_hit();
        int c; logic [31:0] rd;
        do_req(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 2, c, rd);
        checks++; if (c !== 10) begin failures++; $display("FAIL hit_setup_stall: got %0d want 10", c); end
        model_commit(1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678);
        @(posedge clk);
        #1;
        addr_rw = 32'h0000_0010; en_r = 1'b1; u_b_h_w = 3'b010;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hit_stall: got %b want 0", stall); end
        checks++; if (data_r !== 32'h1234_5678) begin failures++; $display("FAIL hit_data: got %h want 12345678", data_r); end
        checks++; if (cache_load !== 1'b1 || cache_store !== 1'b0) begin failures++;
            $display("FAIL hit_load: got load=%b store=%b want 1 0", cache_load, cache_store); end
        checks++; if (mem_bus.mem_cs_o !== 1'b0) begin failures++; $display("FAIL hit_mem_cs: got %b want 0", mem_bus.mem_cs_o); end
        @(posedge clk);
        #1;
        en_r = 1'b0;
    endtask

    task automatic test_clean_miss();
        int c; logic [31:0] rd, exp; int mb, rb;
        exp = exp_load(32'h0000_1020, 3'b010);
        mb = mlog_addr.size(); rb = rep_log.size();
        do_req(1'b1, 1'b0, 3'b010, 32'h0000_1020, '0, 2, c, rd);
        checks++; if (c !== 10) begin failures++; $display("FAIL clean_miss_stall: got %0d want 10", c); end
        checks++; if (rd !== exp) begin failures++; $display("FAIL clean_miss_data: got %h want %h", rd, exp); end
        checks++; if (mlog_addr.size() - mb !== 4 || rep_log.size() - rb !== 4) begin failures++;
            $display("FAIL clean_miss_count: got mem=%0d rep=%0d want 4 4", mlog_addr.size() - mb, rep_log.size() - rb); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (mlog_addr[mb+i] !== 32'h0000_1020 + 32'(4 * i) || mlog_we[mb+i] !== 1'b0 ||
                rep_log[rb+i] !== 32'h0000_1020 + 32'(4 * i)) begin
                failures++;
                $display("FAIL clean_miss_word%0d: got mem=%h we=%b rep=%h want %h", i, mlog_addr[mb+i],
                         mlog_we[mb+i], rep_log[rb+i], 32'h0000_1020 + 32'(4 * i));
            end
        end
        model_commit(1'b0, 3'b010, 32'h0000_1020, '0);
    endtask

    task automatic test_dirty_miss();
        int c; logic [31:0] rd, d0, d1, exp; int mb;
        d0 = $urandom(); d1 = $urandom();
        do_req(1'b0, 1'b1, 3'b010, 32'h0000_0220, d0, 2, c, rd);
        checks++; if (c !== 10) begin failures++; $display("FAIL dirty_setup_stall: got %0d want 10", c); end
        model_commit(1'b1, 3'b010, 32'h0000_0220, d0);
        mb = mlog_addr.size();
        do_req(1'b0, 1'b1, 3'b010, 32'h0000_0420, d1, 2, c, rd);
        checks++; if (c !== 18) begin failures++; $display("FAIL dirty_miss_stall: got %0d want 18", c); end
        checks++; if (mlog_addr.size() - mb !== 8) begin failures++;
            $display("FAIL dirty_miss_count: got %0d want 8", mlog_addr.size() - mb); end
        else for (int i = 0; i < 8; i++) begin
            logic [31:0] ea;
            ea = (i < 4) ? 32'h0000_0220 + 32'(4 * i) : 32'h0000_0420 + 32'(4 * (i - 4));
            checks++;
            if (mlog_addr[mb+i] !== ea || mlog_we[mb+i] !== (i < 4) ||
                (i < 4 && mlog_data[mb+i] !== gold_rd(ea))) begin
                failures++;
                $display("FAIL dirty_miss_word%0d: got addr=%h we=%b data=%h want addr=%h data=%h", i,
                         mlog_addr[mb+i], mlog_we[mb+i], mlog_data[mb+i], ea, gold_rd(ea));
            end
        end
        model_commit(1'b1, 3'b010, 32'h0000_0420, d1);
        exp = exp_load(32'h0000_0420, 3'b010);
        do_req(1'b1, 1'b0, 3'b010, 32'h0000_0420, '0, 2, c, rd);
        checks++; if (c !== 0 || rd !== exp) begin failures++;
            $display("FAIL dirty_store_readback: got stall=%0d data=%h want 0 %h", c, rd, exp); end
    endtask

    task automatic test_both_enables();
        int c; logic [31:0] rd, d;
        d = $urandom();
        @(posedge clk);
        #1;
        addr_rw = 32'h0000_0424; en_r = 1'b1; en_w = 1'b1; u_b_h_w = 3'b010; data_w = d;
        #1;
        checks++; if (cache_store !== 1'b1 || cache_load !== 1'b0 || stall !== 1'b0) begin failures++;
            $display("FAIL both_en: got store=%b load=%b stall=%b want 1 0 0", cache_store, cache_load, stall); end
        @(posedge clk);
        #1;
        en_r = 1'b0; en_w = 1'b0;
        model_commit(1'b1, 3'b010, 32'h0000_0424, d);
        do_req(1'b1, 1'b0, 3'b010, 32'h0000_0424, '0, 1, c, rd);
        checks++; if (rd !== d) begin failures++; $display("FAIL both_en_readback: got %h want %h", rd, d); end
    endtask

    task automatic test_ack_stall();
        int n; logic [31:0] exp;
        exp = exp_load(32'h0000_0830, 3'b010);
        k_lat = 1; block_addr = 32'h0000_0838; block_until = cyc + 100000;
        @(posedge clk);
        #1;
        addr_rw = 32'h0000_0830; en_r = 1'b1; u_b_h_w = 3'b010;
        n = 0;
        @(negedge clk);
        while (mem_bus.mem_addr_o !== 32'h0000_0838 && n < 100) begin n++; @(negedge clk); end
        checks++; if (mem_bus.mem_addr_o !== 32'h0000_0838) begin failures++;
            $display("FAIL ack_stall_reach: got %h want 00000838", mem_bus.mem_addr_o); end
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (mem_bus.mem_addr_o !== 32'h0000_0838 || mem_bus.mem_cs_o !== 1'b1 || cache_replace !== 1'b0) begin
                failures++;
                $display("FAIL ack_stall_hold%0d: got addr=%h cs=%b replace=%b want 00000838 1 0", i,
                         mem_bus.mem_addr_o, mem_bus.mem_cs_o, cache_replace);
            end
            @(negedge clk);
        end
        block_until = cyc;
        n = 0;
        while (stall === 1'b1 && n < 100) begin n++; @(negedge clk); end
        checks++; if (stall !== 1'b0 || data_r !== exp) begin failures++;
            $display("FAIL ack_stall_resume: got stall=%b data=%h want 0 %h", stall, data_r, exp); end
        @(posedge clk);
        #1;
        en_r = 1'b0;
        model_commit(1'b0, 3'b010, 32'h0000_0830, '0);
    endtask

    task automatic test_async_reset();
        int n, c; logic [31:0] rd, exp;
        k_lat = 2;
        @(posedge clk);
        #1;
        addr_rw = 32'h0000_0620; en_r = 1'b1; u_b_h_w = 3'b010;
        n = 0;
        @(negedge clk);
        while (!(mem_bus.mem_we_o === 1'b1 && mem_bus.mem_addr_o[3:2] === 2'd1) && n < 200) begin
            n++; @(negedge clk);
        end
        checks++; if (mem_bus.mem_we_o !== 1'b1) begin failures++; $display("FAIL async_reach_back: got we=%b want 1", mem_bus.mem_we_o); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (mem_bus.mem_cs_o !== 1'b0 || stall !== 1'b0) begin failures++;
            $display("FAIL async_reset_immediate: got cs=%b stall=%b want 0 0", mem_bus.mem_cs_o, stall); end
        en_r = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_bus.mem_cs_o !== 1'b0 || stall !== 1'b0) begin failures++;
            $display("FAIL async_release_idle: got cs=%b stall=%b want 0 0", mem_bus.mem_cs_o, stall); end
        exp = exp_load(32'h0000_0420, 3'b010);
        do_req(1'b1, 1'b0, 3'b010, 32'h0000_0420, '0, 2, c, rd);
        checks++; if (c !== 0 || rd !== exp) begin failures++;
            $display("FAIL async_post_hit: got stall=%0d data=%h want 0 %h", c, rd, exp); end
        exp = exp_load(32'h0000_0620, 3'b010);
        do_req(1'b1, 1'b0, 3'b010, 32'h0000_0620, '0, 2, c, rd);
        checks++; if (c !== 18 || rd !== exp) begin failures++;
            $display("FAIL async_post_miss: got stall=%0d data=%h want 18 %h", c, rd, exp); end
        model_commit(1'b0, 3'b010, 32'h0000_0620, '0);
    endtask

    task automatic test_random();
        logic [2:0] ld_f [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] st_f [3] = '{3'b000, 3'b001, 3'b010};
        for (int i = 0; i < 60; i++) begin
            int op, k, es, c;
            logic [2:0] f; logic [1:0] off; logic [31:0] a, d, ed, rd;
            op = int'($urandom_range(0, 2));
            f  = (op == 0) ? ld_f[$urandom_range(0, 4)] : st_f[$urandom_range(0, 2)];
            off = 2'($urandom_range(0, 3));
            if (f[1:0] == 2'b10) off = 2'b00;
            else if (f[1:0] == 2'b01) off[0] = 1'b0;
            a = {21'h0, 2'($urandom_range(0, 3)), 3'b000, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), off};
            d = $urandom();
            k = int'($urandom_range(1, 3));
            es = exp_stall(a, k);
            ed = exp_load(a, f);
            do_req(op != 1, op != 0, f, a, d, k, c, rd);
            checks++; if (c !== es) begin failures++;
                $display("FAIL rand%0d_stall: addr=%h got %0d want %0d", i, a, c, es); end
            if (op == 0) begin
                checks++; if (rd !== ed) begin failures++;
                    $display("FAIL rand%0d_data: addr=%h fmt=%b got %h want %h", i, a, f, rd, ed); end
            end
            model_commit(op != 0, f, a, d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_miss();
        test_both_enables();
        test_ack_stall();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
